packer_n_w: RTL and testbench
=============================

Name: packer_n_w

Overview:
- Parametrised narrow-to-wide serial-to-parallel packer; successor of the fixed 8-to-32 multi-clock mux.
- Single clock domain. Packs RATIO input beats of IN_W bits into one OUT_W word.
- Uses a valid/ready handshake on both sides, with selectable lane order and an explicit flush of partial words.
- Sits between the byte-wide lane stage and the 32-bit word datapath.

Parameters:
- IN_W, 8: input beat width in bits.
- RATIO, 4: beats per output word; must be 2 or more.
- OUT_W, IN_W*RATIO: output word width; derived, never overridden.
- MSB_FIRST, 1: 1 = first beat lands in the top lane; 0 = first beat lands in lane 0 (LSBs).
- PAD, 0: IN_W-bit value written into unfilled lanes on a flushed partial word.

Ports:
- clk_4f  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- data_in  in  IN_W  input beat.
- valid_in  in  1  beat present.
- ready_in  out  1  packer can accept a beat.
- flush  in  1  emit the pending partial word.
- data_out  out  OUT_W  packed word.
- valid_out  out  1  word present; held until accepted.
- ready_out  in  1  downstream accepts the word.
- partial_out  out  1  current word is a flushed partial.
- beats_out  out  $clog2(RATIO+1)  number of filled lanes in the current word.

Behaviour:
- Reset (reset=1 at posedge): valid_out=0, data_out=0, partial_out=0, beats_out=0, lane counter cnt=0, accumulator=0. Reset mid-word discards all partial data and overrides flush.
- A beat is accepted when valid_in && ready_in at posedge.
  - It is written to lane cnt (MSB_FIRST=1: lane RATIO-1-cnt), then cnt++.
- When the accepted beat is number RATIO:
  - At that same edge the output register loads the assembled word; valid_out=1, partial_out=0, beats_out=RATIO.
  - cnt and the accumulator clear.
  - Latency: valid_out is high in the cycle after the last beat's edge.
- Output handshake: the word is consumed when valid_out && ready_out at posedge; valid_out drops unless a new word loads at that same edge.
  - data_out, partial_out and beats_out stay stable while valid_out=1 && ready_out=0.
- Buffering: the accumulator and output register are independent.
  - The next word may fill while the current word is stalled.
  - ready_in = !(cnt==RATIO-1 && valid_out && !ready_out).
  - This is a combinational path from ready_out to ready_in, and it is intended.
- Gaps (valid_in=0) hold cnt and the accumulator indefinitely; there is no timeout.
- Flush when cnt>0, or when a beat accepted at the same edge leaves cnt>0:
  - Output loads the accumulator including that beat, with unfilled lanes = PAD.
  - partial_out=1, beats_out = number of filled lanes; cnt clears.
- Flush gating and special cases:
  - Flush is honoured only when the output register is free (!valid_out || ready_out); otherwise it is held pending internally until the register frees.
  - Flush with cnt==0 and no accepted beat is a no-op.
  - Flush on the edge that completes the RATIO-th beat yields a normal full word (partial_out=0).
- Word order example, MSB_FIRST=1: beats 55,CC,AA,B8 give 32'h55CCAAB8. MSB_FIRST=0 gives 32'hB8AACC55.

Decomposition:
- Shared package holds:
  - a lane-index function (MSB_FIRST mapping);
  - a $clog2-based counter-width constant;
  - the default IN_W/RATIO constants shared with the unpacker and the 8/32 mux family.
- One natural sub-module: packer_out_reg, the output register with its valid/ready hold logic and the pending-flush flag.

Test Plan:
- Defaults; reset for 2 cycles; feed 55,CC,AA,B8 then DD,BB,A8,34 back-to-back, ready_out=1 -> 32'h55CCAAB8 then 32'hDDBBA834, each valid_out for 1 cycle, beats_out=4, partial_out=0.
- MSB_FIRST=0, same stream -> 32'hB8AACC55, 32'h34A8BBDD.
- ready_out=0 after the first word; stream 8 beats -> word 1 held stable; ready_in falls while the 4th beat of word 2 is offered; raising ready_out -> that beat is accepted and 32'hDDBBA834 follows.
- Beats 11,22, then flush -> data_out=32'h11220000, partial_out=1, beats_out=2; the next 4 beats form a normal word.
- Flush asserted with the 4th beat (55,CC,AA,B8) -> 32'h55CCAAB8, partial_out=0. Flush with cnt=0 -> no valid_out.
- Reset asserted after 2 beats, then 4 new beats 01,02,03,04 -> 32'h01020304 only; no stale lanes, and all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/packer_n_w_pkg.sv
// rtl/packer_n_w_pkg.sv - shared constants and lane mapping for the packer family
package packer_n_w_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_RATIO = 4;

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_RATIO);

    // Maps the arrival order of a beat onto its physical lane within the word.
    function automatic int lane_index(input int beat, input int ratio, input bit msb_first);
        return msb_first ? (ratio - 1 - beat) : beat;
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// rtl/packer_out_reg.sv - output word register with valid/ready hold and pending-flush flag
module packer_out_reg
    import packer_n_w_pkg::*;
#(
    parameter int OUT_W = DEF_IN_W * DEF_RATIO,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             load_partial,
    input  logic [CNT_W-1:0] load_beats,
    input  logic             flush_set,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    output logic             partial_out,
    output logic [CNT_W-1:0] beats_out,
    output logic             flush_pending
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            partial_out <= 1'b0;
            beats_out   <= '0;
        end else if (load) begin
            data_out    <= load_data;
            valid_out   <= 1'b1;
            partial_out <= load_partial;
            beats_out   <= load_beats;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

    // A flush that found the register occupied waits here until any word loads.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            flush_pending <= 1'b0;
        end else if (flush_set) begin
            flush_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/packer_n_w.sv
// rtl/packer_n_w.sv - narrow-to-wide valid/ready packer with lane order and partial flush
module packer_n_w
    import packer_n_w_pkg::*;
#(
    parameter int          IN_W      = DEF_IN_W,
    parameter int          RATIO     = DEF_RATIO,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned PAD       = 0,
    localparam int         OUT_W     = IN_W * RATIO,
    localparam int         CW        = cnt_width(RATIO)
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             flush,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             partial_out,
    output logic [CW-1:0]    beats_out
);

    localparam logic [CW-1:0]   LAST  = CW'(RATIO - 1);
    localparam logic [IN_W-1:0] PAD_V = IN_W'(PAD);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    new_cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] next_acc;
    logic [OUT_W-1:0] word;
    logic             accept;
    logic             full;
    logic             out_free;
    logic             flush_req;
    logic             flush_pending;
    logic             load_partial;
    logic             load;
    logic             flush_set;

    // Only the word-completing beat needs the output register free.
    assign ready_in  = !(cnt == LAST && valid_out && !ready_out);
    assign accept    = valid_in && ready_in;
    assign new_cnt   = cnt + CW'(accept);
    assign full      = accept && (cnt == LAST);
    assign out_free  = !valid_out || ready_out;
    assign flush_req = flush || flush_pending;

    assign load_partial = !full && flush_req && (new_cnt != '0) && out_free;
    assign load         = full || load_partial;
    assign flush_set    = !full && flush && (new_cnt != '0) && !out_free;

    always_comb begin
        next_acc = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (accept && cnt == CW'(k)) begin
                next_acc[lane_index(k, RATIO, MSB_FIRST)*IN_W +: IN_W] = data_in;
            end
        end
        word = next_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) >= new_cnt) begin
                word[lane_index(k, RATIO, MSB_FIRST)*IN_W +: IN_W] = PAD_V;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset || load) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= new_cnt;
            acc <= next_acc;
        end
    end

    packer_out_reg #(
        .OUT_W(OUT_W),
        .CNT_W(CW)
    ) u_out_reg (
        .clk          (clk_4f),
        .reset        (reset),
        .load         (load),
        .load_data    (word),
        .load_partial (load_partial),
        .load_beats   (new_cnt),
        .flush_set    (flush_set),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .partial_out  (partial_out),
        .beats_out    (beats_out),
        .flush_pending(flush_pending)
    );

endmodule

// File: tb/tb_packer_n_w.sv
// tb/tb_packer_n_w.sv - randomized and directed bench for packer_n_w against a beat-queue model
module tb_packer_n_w;

    logic clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    logic        reset;
    logic        valid_in;
    logic        flush;
    logic        ready_out;
    logic [7:0]  data_in;
    logic        rdy_a, rdy_b, vo_a, vo_b, po_a, po_b;
    logic [31:0] do_a, do_b;
    logic [2:0]  bo_a, bo_b;

    packer_n_w dut_a (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy_a), .flush(flush), .data_out(do_a), .valid_out(vo_a),
        .ready_out(ready_out), .partial_out(po_a), .beats_out(bo_a)
    );

    packer_n_w #(.MSB_FIRST(1'b0), .PAD(32'h5A)) dut_b (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy_b), .flush(flush), .data_out(do_b), .valid_out(vo_b),
        .ready_out(ready_out), .partial_out(po_b), .beats_out(bo_b)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] m_b[4];
    int         m_n;
    logic       m_ov, m_p, m_fp;
    logic       exp_rdy;
    bit         cmp_on;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat i is the i-th arrival; unfilled positions take the pad byte.
    function automatic logic [31:0] pack(input logic [7:0] b[4], input int n, input bit msb,
                                         input logic [7:0] pad);
        logic [31:0] w;
        logic [7:0]  v;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            v = (i < n) ? b[i] : pad;
            if (msb) w = {w[23:0], v};
            else     w = w | (32'(v) << (8 * i));
        end
        return w;
    endfunction

    task automatic model_compare();
        check("ready_in_a", 32'(rdy_a), 32'(exp_rdy));
        check("ready_in_b", 32'(rdy_b), 32'(exp_rdy));
        check("valid_out_a", 32'(vo_a), 32'(m_ov));
        check("valid_out_b", 32'(vo_b), 32'(m_ov));
        if (m_ov) begin
            check("data_out_a", do_a, pack(m_b, m_n, 1'b1, 8'h00));
            check("data_out_b", do_b, pack(m_b, m_n, 1'b0, 8'h5A));
            check("partial_out_a", 32'(po_a), 32'(m_p));
            check("partial_out_b", 32'(po_b), 32'(m_p));
            check("beats_out_a", 32'(bo_a), 32'(m_n));
            check("beats_out_b", 32'(bo_b), 32'(m_n));
        end
    endtask

    task automatic model_load(input logic partial);
        for (int i = 0; i < 4; i++) m_b[i] = (i < q.size()) ? q[i] : 8'h00;
        m_n  = q.size();
        m_ov = 1'b1;
        m_p  = partial;
        m_fp = 1'b0;
        q.delete();
    endtask

    task automatic model_edge();
        bit acc, free;
        if (reset) begin
            q.delete();
            m_ov = 1'b0; m_p = 1'b0; m_n = 0; m_fp = 1'b0;
        end else begin
            acc = valid_in && exp_rdy;
            if (acc) q.push_back(data_in);
            free = !m_ov || ready_out;
            if (m_ov && ready_out) m_ov = 1'b0;
            if (q.size() == 4) begin
                model_load(1'b0);
            end else if ((flush || m_fp) && q.size() > 0) begin
                if (free) model_load(1'b1);
                else      m_fp = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r, input bit rst);
        valid_in = v; data_in = d; flush = f; ready_out = r; reset = rst;
        exp_rdy = !(q.size() == 3 && m_ov && !r);
        #1;
        if (cmp_on) model_compare();
        @(posedge clk_4f);
        model_edge();
        @(negedge clk_4f);
    endtask

    task automatic feed4(input logic [31:0] w, input bit r);
        for (int i = 0; i < 4; i++) step(1'b1, w[31-8*i -: 8], 1'b0, r, 1'b0);
    endtask

    task automatic check_word(input string name, input logic [31:0] ea, input logic [31:0] eb,
                              input logic ep, input int en);
        check({name, "_valid"}, 32'(vo_a), 32'h1);
        check({name, "_a"}, do_a, ea);
        check({name, "_b"}, do_b, eb);
        check({name, "_partial"}, 32'(po_a), 32'(ep));
        check({name, "_beats"}, 32'(bo_a), 32'(en));
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 32'(vo_a), 32'h0);
        check({name, "_data"}, do_a, 32'h0);
        check({name, "_partial"}, 32'(po_a), 32'h0);
        check({name, "_beats"}, 32'(bo_a), 32'h0);
    endtask

    initial begin
        q.delete();
        m_ov = 1'b0; m_p = 1'b0; m_n = 0; m_fp = 1'b0;
        for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
        cmp_on = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cmp_on = 1'b1;
        check_zero("reset");

        feed4(32'h55CCAAB8, 1'b1);
        check_word("w1", 32'h55CCAAB8, 32'hB8AACC55, 1'b0, 4);
        feed4(32'hDDBBA834, 1'b1);
        check_word("w2", 32'hDDBBA834, 32'h34A8BBDD, 1'b0, 4);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("w2_single_cycle", 32'(vo_a), 32'h0);

        feed4(32'h55CCAAB8, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, (i == 0) ? 8'hDD : (i == 1) ? 8'hBB : 8'hA8,
                                         1'b0, 1'b0, 1'b0);
        check_word("stall_hold", 32'h55CCAAB8, 32'hB8AACC55, 1'b0, 4);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        check("stall_ready_in", 32'(rdy_a), 32'h0);
        step(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        check_word("stall_release", 32'hDDBBA834, 32'h34A8BBDD, 1'b0, 4);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_word("flush_partial", 32'h11220000, 32'h5A5A2211, 1'b1, 2);
        feed4(32'h01020304, 1'b1);
        check_word("after_flush", 32'h01020304, 32'h04030201, 1'b0, 4);

        for (int i = 0; i < 3; i++) step(1'b1, (i == 0) ? 8'h55 : (i == 1) ? 8'hCC : 8'hAA,
                                         1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hB8, 1'b1, 1'b1, 1'b0);
        check_word("flush_full", 32'h55CCAAB8, 32'hB8AACC55, 1'b0, 4);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("flush_empty_noop", 32'(vo_a), 32'h0);

        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check_zero("mid_reset");
        feed4(32'h01020304, 1'b1);
        check_word("post_reset", 32'h01020304, 32'h04030201, 1'b0, 4);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
